// File: rtl/rans_pkg.sv
// rans_pkg: shared FSM type and size helpers for the rANS byte stack.
package rans_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } stack_state_e;

    // Width of the final encoder state in bits.
    function automatic int state_width(input int resolution, input int symbol_width);
        return resolution + symbol_width;
    endfunction

    // Number of whole symbols needed to hold the encoder state.
    function automatic int state_bytes(input int state_w, input int symbol_width);
        return (state_w + symbol_width - 1) / symbol_width;
    endfunction

endpackage

// File: rtl/rans_stack_ram.sv
// rans_stack_ram: single-port synchronous RAM, DEPTH x WIDTH, 1-cycle read latency.
// The stack never pushes and pops in the same cycle, so one port is enough.
module rans_stack_ram
    import rans_pkg::*;
#(
    parameter  int DEPTH = 4096,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write when enabled; the addressed word is always read into r_rdata.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[addr_i] <= wdata_i;
        end
        r_rdata <= r_mem[addr_i];
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/rans_byte_stack.sv
// rans_byte_stack: collects rANS encoder bytes, appends the final state on
// flush and replays everything in LIFO order through a valid/ready port.
// Optional feature: define RANS_STACK_OVF_EN to add the sticky ovf_o flag.
module rans_byte_stack
    import rans_pkg::*;
#(
    parameter  int RESOLUTION   = 10,
    parameter  int SYMBOL_WIDTH = 8,
    parameter  int DEPTH        = 4096,
    localparam int STATE_WIDTH  = state_width(RESOLUTION, SYMBOL_WIDTH),
    localparam int STATE_BYTES  = state_bytes(STATE_WIDTH, SYMBOL_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    input  logic [SYMBOL_WIDTH-1:0] data_i,
    input  logic                    flush_i,
    input  logic [STATE_WIDTH-1:0]  state_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [SYMBOL_WIDTH-1:0] out_data_o,
    output logic                    out_last_o,
    output logic                    busy_o
`ifdef RANS_STACK_OVF_EN
    ,
    output logic                    ovf_o
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int PADW = STATE_BYTES * SYMBOL_WIDTH;
    localparam int SBW  = $clog2(STATE_BYTES + 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE_CNT  = CW'(1);
    localparam logic [SBW-1:0] SB_LAST  = SBW'(STATE_BYTES - 1);

    stack_state_e            r_state;
    stack_state_e            w_next;
    logic [CW-1:0]           r_count;
    logic [PADW-1:0]         r_shift;
    logic [SBW-1:0]          r_sidx;
    logic                    r_rd_pend;
    logic                    r_rd_last;
    logic                    r_out_vld;
    logic                    r_out_last;
    logic [SYMBOL_WIDTH-1:0] r_out_data;
    logic                    r_skid_vld;
    logic                    r_skid_last;
    logic [SYMBOL_WIDTH-1:0] r_skid_data;

    logic                    w_push_req;
    logic                    w_full;
    logic                    w_we;
    logic                    w_rd;
    logic                    w_accept;
    logic                    w_last_acc;
    logic [1:0]              w_load;
    logic [SYMBOL_WIDTH-1:0] w_wdata;
    logic [SYMBOL_WIDTH-1:0] w_rdata;
    logic [AW-1:0]           w_addr;

    assign w_full     = (r_count == FULL_CNT);
    assign w_push_req = ((r_state == FILL) && valid_i) || (r_state == FLUSH);
    assign w_we       = w_push_req && !w_full;
    assign w_wdata    = (r_state == FLUSH) ? r_shift[SYMBOL_WIDTH-1:0] : data_i;
    assign w_accept   = r_out_vld && out_ready_i;
    assign w_last_acc = w_accept && r_out_last;
    // Bytes held or in flight after this cycle's handoff; at most two fit
    // (output register plus skid slot), which sustains one pop per cycle.
    assign w_load     = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_pend}
                      - {1'b0, w_accept};
    assign w_rd       = (r_state == DRAIN) && (r_count != '0) && (w_load < 2'd2);
    assign w_addr     = w_rd ? AW'(r_count - ONE_CNT) : r_count[AW-1:0];

    rans_stack_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SYMBOL_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .addr_i  (w_addr),
        .wdata_i (w_wdata),
        .rdata_o (w_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= FILL;
        else         r_state <= w_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            FILL:    if (flush_i) w_next = FLUSH;
            FLUSH:   if (r_sidx == SB_LAST) w_next = DRAIN;
            DRAIN:   if (w_last_acc) w_next = FILL;
            default: w_next = FILL;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_o = (r_state != FILL);
    end

    // Stack occupancy and the shifter that feeds state bytes LS byte first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
            r_shift <= '0;
            r_sidx  <= '0;
        end else begin
            if (w_we)      r_count <= r_count + ONE_CNT;
            else if (w_rd) r_count <= r_count - ONE_CNT;
            if ((r_state == FILL) && flush_i) begin
                r_shift <= PADW'(state_i);
                r_sidx  <= '0;
            end else if (r_state == FLUSH) begin
                r_shift <= r_shift >> SYMBOL_WIDTH;
                r_sidx  <= r_sidx + SBW'(1);
            end
        end
    end

    // Pop pipeline: RAM read tag, output register and skid slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_pend   <= 1'b0;
            r_rd_last   <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
            r_skid_data <= '0;
        end else begin
            r_rd_pend <= w_rd;
            r_rd_last <= w_rd && (r_count == ONE_CNT);
            if (w_accept) begin
                if (r_skid_vld) begin
                    r_out_vld   <= 1'b1;
                    r_out_data  <= r_skid_data;
                    r_out_last  <= r_skid_last;
                    r_skid_vld  <= r_rd_pend;
                    r_skid_data <= w_rdata;
                    r_skid_last <= r_rd_pend && r_rd_last;
                end else begin
                    r_out_vld  <= r_rd_pend;
                    r_out_last <= r_rd_pend && r_rd_last;
                    if (r_rd_pend) r_out_data <= w_rdata;
                end
            end else if (!r_out_vld) begin
                if (r_rd_pend) begin
                    r_out_vld  <= 1'b1;
                    r_out_data <= w_rdata;
                    r_out_last <= r_rd_last;
                end
            end else if (r_rd_pend) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= w_rdata;
                r_skid_last <= r_rd_last;
            end
        end
    end

    assign out_valid_o = r_out_vld;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_out_last;

`ifdef RANS_STACK_OVF_EN
    logic w_drop;
    logic r_ovf;

    assign w_drop = w_push_req && w_full;

    // Sticky overflow flag, cleared when the block finishes draining.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         r_ovf <= 1'b0;
        else if (w_last_acc) r_ovf <= 1'b0;
        else if (w_drop)     r_ovf <= 1'b1;
    end

    assign ovf_o = r_ovf;
`endif

endmodule

// File: tb/tb_rans_byte_stack.sv
// tb_rans_byte_stack: table vectors plus randomized blocks checked against a
// queue-based LIFO model of the byte stack (DEPTH=8 to reach saturation).
module tb_rans_byte_stack;

    localparam int TB_DEPTH = 8;
    localparam int SB       = 3;
    localparam int LAT      = SB + 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        flush_i;
    logic [17:0] state_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic        out_last_o;
    logic        busy_o;
`ifdef RANS_STACK_OVF_EN
    logic        ovf_o;
`endif

    rans_byte_stack #(
        .RESOLUTION   (10),
        .SYMBOL_WIDTH (8),
        .DEPTH        (TB_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .flush_i     (flush_i),
        .state_i     (state_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
`ifdef RANS_STACK_OVF_EN
        ,
        .ovf_o       (ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        int          n;
        logic [63:0] din;
        logic [17:0] st;
        bit          fb_en;
        logic [7:0]  fb;
        int          mode;
        bit          pulse;
        int          nexp;
        logic [87:0] xp;
    } vec_t;

    vec_t       tbl [5];
    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         first_vld;
    logic [7:0] g_in[$];
    logic [7:0] g_exp[$];
    logic [7:0] got_d[$];
    logic       got_l[$];
    int         got_t[$];
    bit         exp_drop;
    bit         ovf_first;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, want);
        end
    endtask

    // Sample outputs at the falling edge, then advance one clock.
    task automatic step();
        if (prev_stall) begin
            check("stall_valid", 32'(out_valid_o), 32'd1);
            check("stall_data", 32'(out_data_o), 32'(prev_data));
            check("stall_last", 32'(out_last_o), 32'(prev_last));
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_data  = out_data_o;
        prev_last  = out_last_o;
        if (out_valid_o && first_vld < 0) begin
            first_vld = cyc;
`ifdef RANS_STACK_OVF_EN
            ovf_first = ovf_o;
`endif
        end
        if (out_valid_o && out_ready_i) begin
            got_d.push_back(out_data_o);
            got_l.push_back(out_last_o);
            got_t.push_back(cyc);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    // Reference: saturating LIFO of data bytes, optional flush byte, state bytes.
    task automatic model(input logic [17:0] st, input bit fb_en, input logic [7:0] fb);
        logic [7:0]  all[$];
        logic [7:0]  stk[$];
        logic [23:0] pad;
        all = g_in;
        if (fb_en) all.push_back(fb);
        pad = {6'd0, st};
        for (int i = 0; i < SB; i++) all.push_back(pad[8*i +: 8]);
        exp_drop = 1'b0;
        stk = {};
        foreach (all[i]) begin
            if (stk.size() < TB_DEPTH) stk.push_back(all[i]);
            else exp_drop = 1'b1;
        end
        g_exp = {};
        while (stk.size() > 0) g_exp.push_back(stk.pop_back());
    endtask

    task automatic run_block(input logic [17:0] st, input bit fb_en, input logic [7:0] fb,
                             input int mode, input bit pulse, input bit gaps, input string tag);
        int flush_cyc;
        int k;
        got_d = {};
        got_l = {};
        got_t = {};
        first_vld = -1;
        out_ready_i = 1'b1;
        foreach (g_in[i]) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    valid_i = 1'b0; flush_i = 1'b0; data_i = 8'($urandom);
                    step();
                end
            end
            valid_i = 1'b1; flush_i = 1'b0; data_i = g_in[i];
            step();
        end
        valid_i = fb_en; data_i = fb; flush_i = 1'b1; state_i = st;
        flush_cyc = cyc;
        step();
        valid_i = 1'b0; flush_i = 1'b0;
        check({tag, "_busy"}, 32'(busy_o), 32'd1);
        k = 0;
        while (!(got_l.size() > 0 && got_l[got_l.size()-1]) && k < 4*TB_DEPTH + 40) begin
            case (mode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = (k % 2 == 0);
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (pulse) begin
                valid_i = 1'($urandom_range(0, 1));
                flush_i = 1'($urandom_range(0, 1));
                data_i  = 8'($urandom);
                state_i = 18'($urandom);
            end
            step();
            k++;
        end
        valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        if (!(got_l.size() > 0 && got_l[got_l.size()-1]))
            check({tag, "_drain_timeout"}, 32'd0, 32'd1);
        check({tag, "_latency"}, 32'(first_vld - flush_cyc), 32'(LAT));
        check({tag, "_nbytes"}, 32'(got_d.size()), 32'(g_exp.size()));
        for (int i = 0; i < g_exp.size(); i++) begin
            if (i < got_d.size()) begin
                check($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(g_exp[i]));
                check($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == g_exp.size() - 1));
            end
        end
        if (mode == 0 && got_t.size() > 0)
            check({tag, "_thruput"}, 32'(got_t[got_t.size()-1] - flush_cyc),
                  32'(LAT + g_exp.size() - 1));
        check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_idle_valid"}, 32'(out_valid_o), 32'd0);
`ifdef RANS_STACK_OVF_EN
        check({tag, "_ovf"}, 32'(ovf_first), 32'(exp_drop));
        check({tag, "_ovf_clr"}, 32'(ovf_o), 32'd0);
`endif
    endtask

    initial begin
        tbl[0] = '{n:3, din:64'h332211, st:18'h2ABCD, fb_en:1'b0, fb:8'h00,
                   mode:0, pulse:1'b0, nexp:6, xp:88'h112233CDAB02};
        tbl[1] = '{n:0, din:64'h0, st:18'h00400, fb_en:1'b0, fb:8'h00,
                   mode:0, pulse:1'b0, nexp:3, xp:88'h000400};
        tbl[2] = '{n:3, din:64'h332211, st:18'h2ABCD, fb_en:1'b0, fb:8'h00,
                   mode:1, pulse:1'b1, nexp:6, xp:88'h112233CDAB02};
        tbl[3] = '{n:8, din:64'h0807060504030201, st:18'h3FFFF, fb_en:1'b0, fb:8'h00,
                   mode:0, pulse:1'b0, nexp:8, xp:88'h0102030405060708};
        tbl[4] = '{n:2, din:64'h2211, st:18'h00001, fb_en:1'b1, fb:8'h5A,
                   mode:0, pulse:1'b0, nexp:6, xp:88'h11225A010000};

        rst_ni = 1'b0; valid_i = 1'b0; data_i = '0; flush_i = 1'b0;
        state_i = '0; out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        check("rst_data", 32'(out_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
`ifdef RANS_STACK_OVF_EN
        check("rst_ovf", 32'(ovf_o), 32'd0);
`endif
        rst_ni = 1'b1;

        for (int t = 0; t < 5; t++) begin
            g_in = {};
            for (int i = 0; i < tbl[t].n; i++) g_in.push_back(tbl[t].din[8*i +: 8]);
            model(tbl[t].st, tbl[t].fb_en, tbl[t].fb);
            g_exp = {};
            for (int i = 0; i < tbl[t].nexp; i++) g_exp.push_back(tbl[t].xp[8*i +: 8]);
            run_block(tbl[t].st, tbl[t].fb_en, tbl[t].fb, tbl[t].mode, tbl[t].pulse,
                      1'b0, $sformatf("vec%0d", t));
        end

        // Reset in the middle of a drain discards everything.
        got_d = {}; got_l = {}; got_t = {}; first_vld = -1;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; flush_i = 1'b0; data_i = 8'($urandom);
            step();
        end
        valid_i = 1'b0; flush_i = 1'b1; state_i = 18'($urandom);
        step();
        flush_i = 1'b0; out_ready_i = 1'b1;
        for (int k = 0; k < 40 && got_d.size() < 2; k++) step();
        check("mid_xfers", 32'(got_d.size() >= 2), 32'd1);
        check("mid_busy", 32'(busy_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_last", 32'(out_last_o), 32'd0);
        check("mid_rst_data", 32'(out_data_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        prev_stall = 1'b0;
        g_in = {8'($urandom), 8'($urandom)};
        state_i = 18'($urandom);
        model(state_i, 1'b0, 8'h00);
        run_block(state_i, 1'b0, 8'h00, 0, 1'b0, 1'b0, "post_rst");

        // Randomized back-to-back blocks against the model.
        for (int b = 0; b < 30; b++) begin
            logic [17:0] st;
            bit          fb_en;
            logic [7:0]  fb;
            int          n;
            n = $urandom_range(0, 11);
            g_in = {};
            for (int i = 0; i < n; i++) g_in.push_back(8'($urandom));
            st    = 18'($urandom);
            fb_en = 1'($urandom_range(0, 1));
            fb    = 8'($urandom);
            model(st, fb_en, fb);
            run_block(st, fb_en, fb, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $sformatf("rnd%0d", b));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rans_byte_stack.md
RANS_BYTE_STACK -- requirements
Module: rans_byte_stack

Interface
REQ-001 SHALL have parameter RESOLUTION, default 10, probability resolution bits; sets STATE_WIDTH = RESOLUTION + SYMBOL_WIDTH.
REQ-002 SHALL have parameter SYMBOL_WIDTH, default 8, width of one emitted byte.
REQ-003 SHALL have parameter DEPTH, default 4096, stack capacity in bytes; legal values are powers of two >= 2*STATE_BYTES.
REQ-004 SHALL derive STATE_BYTES = ceil(STATE_WIDTH/SYMBOL_WIDTH), which is 3 at defaults.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; port clk_i, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port valid_i, input, 1 bit, encoder byte strobe.
REQ-008 SHALL have port data_i, input, SYMBOL_WIDTH bits, encoder byte.
REQ-009 SHALL have port flush_i, input, 1 bit, end-of-block pulse.
REQ-010 SHALL have port state_i, input, STATE_WIDTH bits, final encoder state, sampled with flush_i.
REQ-011 SHALL have port out_valid_o, output, 1 bit, output byte available.
REQ-012 SHALL have port out_ready_i, input, 1 bit, consumer accepts.
REQ-013 SHALL have port out_data_o, output, SYMBOL_WIDTH bits, output byte.
REQ-014 SHALL have port out_last_o, output, 1 bit, marks the final byte of the block.
REQ-015 SHALL have port busy_o, output, 1 bit, high in FLUSH and DRAIN.

Function
REQ-016 SHALL implement FSM states FILL, FLUSH and DRAIN.
REQ-017 In FILL, each cycle with valid_i=1 SHALL push data_i and increment count.
REQ-018 In FILL, flush_i=1 SHALL capture state_i and enter FLUSH; if valid_i is also 1 in that cycle, data_i SHALL be pushed first in that same cycle.
REQ-019 FLUSH SHALL push the captured state over STATE_BYTES cycles, least-significant byte first (upper bits zero-padded), then enter DRAIN.
REQ-020 DRAIN SHALL pop in LIFO order, so the state MS byte emerges first and the first encoder byte emerges last.
REQ-021 A byte SHALL transfer only on a cycle where out_valid_o=1 and out_ready_i=1.
REQ-022 out_data_o and out_last_o SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-023 out_valid_o SHALL rise exactly 2 cycles after DRAIN entry, covering the synchronous RAM read plus the output register.
REQ-024 Throughput SHALL be 1 byte/cycle while out_ready_i is held high, which requires a prefetch/skid register.
REQ-025 out_last_o SHALL be 1 only with the byte whose pop empties the stack.
REQ-026 Acceptance of the out_last_o byte SHALL return the FSM to FILL with count=0; the next cycle SHALL accept valid_i.
REQ-027 valid_i and flush_i SHALL be ignored while busy_o=1.
REQ-028 A push with count==DEPTH SHALL be dropped and count SHALL saturate; this applies to data bytes and state bytes alike.
REQ-029 A flush with count==0 SHALL still emit exactly STATE_BYTES bytes.
REQ-030 count SHALL be clog2(DEPTH)+1 bits wide, and the stack pointer SHALL never wrap.

Reset
REQ-031 rst_ni low SHALL asynchronously force FILL, count=0, out_valid_o=0, out_last_o=0, busy_o=0, out_data_o=0 and the captured state to 0.
REQ-032 Reset mid-FLUSH or mid-DRAIN SHALL discard all stored bytes; RAM contents are don't-care.
REQ-033 Deassertion SHALL be used synchronously, i.e. the first push is accepted on the first rising edge after rst_ni goes high.

Configuration
REQ-034 With macro RANS_STACK_OVF_EN defined, the block SHALL add output port ovf_o (1 bit), a sticky flag set on any dropped push and cleared only by reset or by the cycle the FSM enters FILL from DRAIN.
REQ-035 Without RANS_STACK_OVF_EN, ovf_o SHALL be absent and dropped pushes SHALL be silent; all other behaviour is identical.

Structure
REQ-036 Shared package rans_pkg SHALL hold STATE_WIDTH and STATE_BYTES derivation functions and the stack_state_e enum {FILL, FLUSH, DRAIN}.
REQ-037 Storage SHALL be sub-module rans_stack_ram: single-port synchronous RAM, DEPTH x SYMBOL_WIDTH, 1-cycle read latency; one port suffices because push and pop never coincide.

Verification
REQ-038 Push 0x11,0x22,0x33, flush with state_i=0x2ABCD, ready=1 -> output 0x02,0xAB,0xCD,0x33,0x22,0x11, last on 0x11, then FILL.
REQ-039 Flush with count=0, state_i=0x00400 -> output 0x00,0x04,0x00 with last on the third byte.
REQ-040 Same traffic as REQ-038 with out_ready_i toggling 1010... -> identical byte order, data stable during stalls, no duplicates.
REQ-041 DEPTH=8: push 8 bytes, then flush -> state bytes dropped, 8 bytes out, ovf_o=1 (macro on).
REQ-042 valid_i and flush_i pulsed during DRAIN -> no effect on output; rst_ni pulsed mid-DRAIN -> out_valid_o=0 immediately, count=0.
REQ-043 valid_i=1 with flush_i=1 in the same cycle with data_i=0x5A -> 0x5A is the last byte before the previously pushed bytes, immediately after the state bytes.
